// File: rtl/operand_select_stage.sv
// operand_select_stage
// Registered N-way operand multiplexer behind a valid/ready stage with a
// 2-entry skid buffer (main register drives the outputs, skid register
// absorbs the one extra beat accepted after the consumer stalls).
//
// Ports:
//   clk          single clock, rising edge
//   resetN       synchronous active-low reset
//   inValid      producer offers a beat on select/inputBus
//   inReady      stage can accept a beat (function of state only)
//   select       source index for the beat
//   inputBus     packed sources, source k at [k*WIDTH +: WIDTH]
//   outValid     chosenValue/selectError hold a beat
//   outReady     consumer accepts the beat
//   chosenValue  selected operand (0 when select was out of range)
//   selectError  beat had select >= NUM_INPUTS
//   beatCount    completed output handshakes, modulo 2^16
module operand_select_stage #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [SEL_W-1:0]            select,
  input  logic [NUM_INPUTS*WIDTH-1:0] inputBus,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [WIDTH-1:0]            chosenValue,
  output logic                        selectError,
  output logic [15:0]                 beatCount
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           state;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_data;
  logic             main_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic [15:0]      count_q;

  logic [WIDTH-1:0] pick_data;
  logic             pick_err;
  logic             accept;
  logic             pop;

  // Out-of-range select falls through the loop: data 0, error flagged.
  always_comb begin
    pick_data = '0;
    pick_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (32'(select) == k) begin
        pick_data = inputBus[k*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  assign accept = inValid && in_ready_q;
  assign pop    = out_valid_q && outReady;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data   <= '0;
      main_err    <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
      count_q     <= '0;
    end else begin
      if (pop) begin
        count_q <= count_q + 16'd1;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data   <= pick_data;
            main_err    <= pick_err;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= pick_data;
            main_err  <= pick_err;
          end else if (accept) begin
            skid_data  <= pick_data;
            skid_err   <= pick_err;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_data  <= skid_data;
            main_err   <= skid_err;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign inReady     = in_ready_q;
  assign outValid    = out_valid_q;
  assign chosenValue = main_data;
  assign selectError = main_err;
  assign beatCount   = count_q;

endmodule

// File: tb/tb_operand_select_stage.sv
// Testbench for operand_select_stage: directed checks on a 16x4 and a 16x3
// instance, plus two randomized sweeps (32x8, 8x2) with queue scoreboards.
module tb_operand_select_stage;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;
  initial begin
    n_pass  = 0;
    n_total = 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance 0: WIDTH=16, NUM_INPUTS=4 ----------------
  logic        rst0;
  logic        iv0, ir0, ov0, or0, err0;
  logic [1:0]  sel0;
  logic [63:0] bus0;
  logic [15:0] cv0, bc0;
  logic [15:0] src0 [4];
  logic [16:0] q0 [$];

  operand_select_stage #(.WIDTH(16), .NUM_INPUTS(4)) u0 (
    .clk(clk), .resetN(rst0), .inValid(iv0), .inReady(ir0), .select(sel0),
    .inputBus(bus0), .outValid(ov0), .outReady(or0), .chosenValue(cv0),
    .selectError(err0), .beatCount(bc0)
  );

  task automatic set0(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
    src0[0] = a; src0[1] = b; src0[2] = c; src0[3] = d;
    bus0 = {d, c, b, a};
  endtask

  // Scoreboard for instance 0: pop/compare first, then record new accept.
  always @(negedge clk) begin
    if (rst0) begin
      if (ov0 && or0) begin
        check("u0_sb_nonempty", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) begin
          logic [16:0] e;
          e = q0.pop_front();
          check("u0_data", 64'(cv0), 64'(e[15:0]));
          check("u0_err", 64'(err0), 64'(e[16]));
        end
      end
      if (iv0 && ir0) q0.push_back({1'b0, src0[sel0]});
    end
  end

  // ---------------- instance 1: WIDTH=16, NUM_INPUTS=3 ----------------
  logic        iv1, ir1, ov1, or1, err1;
  logic [1:0]  sel1;
  logic [47:0] bus1;
  logic [15:0] cv1, bc1;

  operand_select_stage #(.WIDTH(16), .NUM_INPUTS(3)) u1 (
    .clk(clk), .resetN(rst0), .inValid(iv1), .inReady(ir1), .select(sel1),
    .inputBus(bus1), .outValid(ov1), .outReady(or1), .chosenValue(cv1),
    .selectError(err1), .beatCount(bc1)
  );

  // ---------------- randomized sweeps ----------------
  logic rst_sw;
  initial begin
    rst_sw = 1'b0;
    repeat (2) step();
    rst_sw = 1'b1;
  end

  for (genvar g = 0; g < 2; g++) begin : sw
    localparam int W = (g == 0) ? 32 : 8;
    localparam int N = (g == 0) ? 8 : 2;
    localparam int S = $clog2(N);
    logic             iv, ir, ov, orr, err, done;
    logic [S-1:0]     sel;
    logic [N*W-1:0]   bus;
    logic [W-1:0]     cv;
    logic [15:0]      bc;
    logic [W-1:0]     src [N];
    logic [W:0]       q [$];
    int unsigned      pops;

    operand_select_stage #(.WIDTH(W), .NUM_INPUTS(N)) dut (
      .clk(clk), .resetN(rst_sw), .inValid(iv), .inReady(ir), .select(sel),
      .inputBus(bus), .outValid(ov), .outReady(orr), .chosenValue(cv),
      .selectError(err), .beatCount(bc)
    );

    always @(negedge clk) begin
      if (rst_sw) begin
        if (ov && orr) begin
          pops++;
          check("sw_sb_nonempty", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            logic [W:0] e;
            e = q.pop_front();
            check("sw_data", 64'(cv), 64'(e[W-1:0]));
            check("sw_err", 64'(err), 64'(e[W]));
          end
        end
        if (iv && ir) begin
          if (32'(sel) < N) q.push_back({1'b0, src[sel]});
          else q.push_back({1'b1, {W{1'b0}}});
        end
      end
    end

    initial begin
      done = 1'b0;
      pops = 0;
      iv = 1'b0;
      orr = 1'b0;
      sel = '0;
      bus = '0;
      for (int k = 0; k < N; k++) src[k] = '0;
      wait (rst_sw);
      step();
      for (int c = 0; c < 10000; c++) begin
        iv  = ($urandom_range(0, 3) != 0);
        orr = ($urandom_range(0, 2) != 0);
        sel = S'($urandom_range(0, (1 << S) - 1));
        for (int k = 0; k < N; k++) begin
          src[k] = W'($urandom);
          bus[k*W +: W] = src[k];
        end
        step();
      end
      iv  = 1'b0;
      orr = 1'b1;
      repeat (4) step();
      check("sw_no_loss", 64'(q.size()), 64'd0);
      check("sw_count", 64'(bc), 64'(pops[15:0]));
      done = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst0 = 1'b0;
    iv0 = 1'b0; or0 = 1'b0; sel0 = '0;
    set0(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    iv1 = 1'b0; or1 = 1'b0; sel1 = '0;
    bus1 = {16'h9ABC, 16'h5678, 16'h1234};
    step();
    step();
    check("rst_outValid", 64'(ov0), 64'd0);
    check("rst_inReady", 64'(ir0), 64'd1);
    check("rst_chosen", 64'(cv0), 64'd0);
    check("rst_err", 64'(err0), 64'd0);
    check("rst_count", 64'(bc0), 64'd0);

    // Stream at full throughput.
    rst0 = 1'b1;
    or0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel0 = 2'(i);
      iv0 = 1'b1;
      step();
      check("stream_valid", 64'(ov0), 64'd1);
      check("stream_data", 64'(cv0), 64'(src0[i]));
      check("stream_ready", 64'(ir0), 64'd1);
    end
    iv0 = 1'b0;
    step();
    check("stream_count", 64'(bc0), 64'd4);
    check("stream_empty", 64'(ov0), 64'd0);

    // Backpressure fill.
    set0(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h4444);
    or0 = 1'b0;
    iv0 = 1'b1;
    sel0 = 2'd0;
    step();
    check("bp_ready_one", 64'(ir0), 64'd1);
    check("bp_head_a", 64'(cv0), 64'hAAAA);
    sel0 = 2'd1;
    step();
    check("bp_ready_two", 64'(ir0), 64'd0);
    check("bp_hold_a", 64'(cv0), 64'hAAAA);
    sel0 = 2'd2;
    step();
    check("bp_c_held", 64'(ir0), 64'd0);
    check("bp_still_a", 64'(cv0), 64'hAAAA);
    or0 = 1'b1;
    step();
    check("bp_b_next", 64'(cv0), 64'hBBBB);
    check("bp_ready_back", 64'(ir0), 64'd1);
    step();
    check("bp_c_next", 64'(cv0), 64'hCCCC);
    iv0 = 1'b0;
    step();
    check("bp_empty", 64'(ov0), 64'd0);
    check("bp_count", 64'(bc0), 64'd7);

    // Out-of-range select on the 3-input instance.
    sel1 = 2'd3;
    iv1 = 1'b1;
    step();
    check("oor_valid", 64'(ov1), 64'd1);
    check("oor_data", 64'(cv1), 64'h0);
    check("oor_err", 64'(err1), 64'd1);
    sel1 = 2'd1;
    or1 = 1'b1;
    step();
    check("oor_next_data", 64'(cv1), 64'h5678);
    check("oor_next_err", 64'(err1), 64'd0);
    check("oor_count1", 64'(bc1), 64'd1);
    iv1 = 1'b0;
    step();
    check("oor_empty", 64'(ov1), 64'd0);
    check("oor_count2", 64'(bc1), 64'd2);

    // Reset while holding two beats.
    set0(16'hD00D, 16'hE00E, 16'h0F0F, 16'h1234);
    or0 = 1'b0;
    iv0 = 1'b1;
    sel0 = 2'd0;
    step();
    sel0 = 2'd1;
    step();
    check("rm_full", 64'(ir0), 64'd0);
    check("rm_count_pre", 64'(bc0), 64'd7);
    rst0 = 1'b0;
    or0 = 1'b1;
    sel0 = 2'd2;
    step();
    q0.delete();
    check("rm_outValid", 64'(ov0), 64'd0);
    check("rm_inReady", 64'(ir0), 64'd1);
    check("rm_chosen", 64'(cv0), 64'd0);
    check("rm_count", 64'(bc0), 64'd0);
    rst0 = 1'b1;
    iv0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rm_no_stale", 64'(ov0), 64'd0);
    end

    // Counter wrap: 65535 random beats streamed, then one more.
    or0 = 1'b1;
    iv0 = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      set0(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      sel0 = 2'($urandom_range(0, 3));
      step();
    end
    iv0 = 1'b0;
    step();
    check("wrap_ffff", 64'(bc0), 64'hFFFF);
    iv0 = 1'b1;
    step();
    iv0 = 1'b0;
    step();
    check("wrap_zero", 64'(bc0), 64'h0000);
    check("wrap_empty", 64'(ov0), 64'd0);
    check("u0_no_loss", 64'(q0.size()), 64'd0);

    wait (sw[0].done && sw[1].done);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
